// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, opcodes, FSM states.
package rv_enc_pkg;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] F3_SR = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word, plus immediate range flag.
// Range checking is compiled in only when RV_ENC_RANGE_CHECK_EN is defined.
module rv_imm_pack
   import rv_enc_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        range_err
);

   always_comb begin
      word = '0;
      case (fmt)
         FMT_R: word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
         FMT_I: begin
            word = {imm[11:0], rs1, funct3, rd, op};
            // Shift-right immediates carry the arithmetic/logical select in bit 30
            if (op == OP_I && funct3 == F3_SR) begin
               word[30] = funct7b5;
            end
         end
         FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         FMT_U: word = {imm[31:12], rd, op};
         FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: word = '0;
      endcase
   end

`ifdef RV_ENC_RANGE_CHECK_EN
   logic fit_12;
   logic fit_13;
   logic fit_21;

   // A value fits N signed bits when every bit above N-1 equals the sign bit
   assign fit_12 = (imm[31:11] == {21{imm[11]}});
   assign fit_13 = (imm[31:12] == {20{imm[12]}});
   assign fit_21 = (imm[31:20] == {12{imm[20]}});

   always_comb begin
      range_err = 1'b0;
      case (fmt)
         FMT_I, FMT_S: range_err = ~fit_12;
         FMT_B:        range_err = ~fit_13 | imm[0];
         FMT_J:        range_err = ~fit_21 | imm[0];
         FMT_U:        range_err = (imm[11:0] != 12'h000);
         default:      range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// Streams decoded RV32I fields into instruction memory, one registered write per beat.
// Optional immediate range checking via RV_ENC_RANGE_CHECK_EN.
module rv_instr_encoder
   import rv_enc_pkg::*;
#(
   parameter int          DEPTH = 64,
   parameter logic [31:0] BASE  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [2:0]  fmt,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        busy,
   output logic        done,
   output logic        full,
   output logic        err
);

   localparam int             CW        = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  LAST_SLOT = CW'(DEPTH - 1);

   state_t         state_reg, state_next;
   logic [CW-1:0]  count_reg;
   logic [31:0]    addr_reg;
   logic           we_reg;
   logic [31:0]    waddr_reg;
   logic [31:0]    wdata_reg;
   logic           full_reg;
   logic           err_reg;

   logic [31:0]    packed_word;
   logic           range_err;
   logic           accept;
   logic           drop;
   logic           write_en;
   logic           count_hit;

   rv_imm_pack u_pack (
      .fmt       (fmt),
      .op        (op),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .word      (packed_word),
      .range_err (range_err)
   );

   assign in_ready  = (state_reg == ST_LOAD);
   assign accept    = in_valid & in_ready;
   assign drop      = (fmt > FMT_J) | range_err;
   assign write_en  = accept & ~drop;
   assign count_hit = write_en & (count_reg == LAST_SLOT);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_LOAD;
         ST_LOAD: if (accept && (in_last || count_hit)) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         addr_reg  <= BASE;
         we_reg    <= 1'b0;
         waddr_reg <= BASE;
         wdata_reg <= '0;
         full_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         we_reg    <= write_en;
         if (state_reg == ST_IDLE && start) begin
            count_reg <= '0;
            addr_reg  <= BASE;
            full_reg  <= 1'b0;
            err_reg   <= 1'b0;
         end
         if (write_en) begin
            waddr_reg <= addr_reg;
            wdata_reg <= packed_word;
            addr_reg  <= addr_reg + 32'd4;
            count_reg <= count_reg + CW'(1);
         end
         if (count_hit) full_reg <= 1'b1;
         if (accept && drop) err_reg <= 1'b1;
      end
   end

   assign imem_we    = we_reg;
   assign imem_addr  = waddr_reg;
   assign imem_wdata = wdata_reg;
   assign busy       = (state_reg != ST_IDLE);
   assign done       = (state_reg == ST_DONE);
   assign full       = full_reg;
   assign err        = err_reg;

endmodule
